// File: rtl/brg_xcel_pkg.sv
// Shared definitions for the accelerator memory-master adapter: field widths,
// the load-ID layout and the elaboration-time width check.
package brg_xcel_pkg;

    // Width of a field that indexes n entries (never narrower than one bit).
    function automatic int field_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // True when a load ID of lid_w bits can carry {chan, slot}.
    function automatic bit load_id_fits(input int num_chan, input int max_out, input int lid_w);
        return (lid_w >= ($clog2(num_chan) + $clog2(max_out)));
    endfunction

    // Decoded load ID; the chan field keeps every bit above the slot so that
    // a non-zero pad shows up as an out-of-range channel.
    localparam int LidFieldW = 32;

    typedef struct packed {
        logic [LidFieldW-1:0] chan;
        logic [LidFieldW-1:0] slot;
    } load_id_s;

    // Split a raw load ID into its channel and slot fields.
    function automatic load_id_s decode_load_id(input logic [31:0] id, input int slot_shift);
        load_id_s   d;
        logic [31:0] mask;
        mask   = (32'd1 << slot_shift) - 32'd1;
        d.chan = id >> slot_shift;
        d.slot = id & mask;
        return d;
    endfunction

    // Pack a channel and slot into a raw load ID.
    function automatic logic [31:0] encode_load_id(input logic [31:0] chan, input logic [31:0] slot,
                                                   input int slot_shift);
        return (chan << slot_shift) | slot;
    endfunction

endpackage

// File: rtl/brg_xcel_tag_table.sv
// Per-channel bookkeeping: which load slots are in flight, the caller opaque
// value stored for each slot, and the one-entry response register that hands
// returned loads back to the channel.
module brg_xcel_tag_table
    import brg_xcel_pkg::*;
#(
    parameter  int max_out_p    = 8,
    parameter  int opq_width_p  = 8,
    parameter  int data_width_p = 32,
    localparam int SlotW        = field_w(max_out_p)
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    alloc_v_i,
    input  logic [opq_width_p-1:0]  alloc_opq_i,
    output logic [SlotW-1:0]        alloc_slot_o,
    output logic                    has_free_o,
    output logic [max_out_p-1:0]    slot_busy_o,
    input  logic                    ret_v_i,
    input  logic [SlotW-1:0]        ret_slot_i,
    input  logic [data_width_p-1:0] ret_data_i,
    output logic                    can_accept_o,
    output logic                    resp_v_o,
    output logic [data_width_p-1:0] resp_data_o,
    output logic [opq_width_p-1:0]  resp_opq_o,
    input  logic                    resp_ready_i,
    output logic                    busy_o
);

    logic [max_out_p-1:0]   free_r;
    logic [opq_width_p-1:0] opq_ram [max_out_p];
    logic                   resp_v_r;
    logic [data_width_p-1:0] resp_data_r;
    logic [opq_width_p-1:0] resp_opq_r;

    assign has_free_o   = |free_r;
    assign slot_busy_o  = ~free_r;
    assign can_accept_o = ~resp_v_r | resp_ready_i;
    assign resp_v_o     = resp_v_r;
    assign resp_data_o  = resp_data_r;
    assign resp_opq_o   = resp_opq_r;
    assign busy_o       = ~(&free_r) | resp_v_r;

    // Lowest-numbered free slot, taken from the registered free vector only.
    always_comb begin
        alloc_slot_o = '0;
        for (int i = max_out_p - 1; i >= 0; i--) begin
            if (free_r[i]) begin
                alloc_slot_o = SlotW'(i);
            end
        end
    end

    // Claim a slot on an accepted load and release one on a good return.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            free_r <= '1;
        end else begin
            if (alloc_v_i) begin
                free_r[alloc_slot_o] <= 1'b0;
            end
            if (ret_v_i) begin
                free_r[ret_slot_i] <= 1'b1;
            end
        end
    end

    // Opaque storage is written at allocation; contents are don't-care until then.
    always_ff @(posedge clk_i) begin
        if (alloc_v_i) begin
            opq_ram[alloc_slot_o] <= alloc_opq_i;
        end
    end

    // Response register: a return refills it (even while draining), otherwise a handshake empties it.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            resp_v_r    <= 1'b0;
            resp_data_r <= '0;
            resp_opq_r  <= '0;
        end else if (ret_v_i) begin
            resp_v_r    <= 1'b1;
            resp_data_r <= ret_data_i;
            resp_opq_r  <= opq_ram[ret_slot_i];
        end else if (resp_v_r && resp_ready_i) begin
            resp_v_r    <= 1'b0;
        end
    end

endmodule

// File: rtl/brg_xcel_mem_adapter.sv
// Memory-master adapter: round-robin arbitration of N accelerator request
// channels onto one endpoint master port, load-ID tagging, and routing of
// returned loads back to the issuing channel with its opaque value.
module brg_xcel_mem_adapter
    import brg_xcel_pkg::*;
#(
    parameter int num_chan_p      = 2,
    parameter int max_out_p       = 8,
    parameter int data_width_p    = 32,
    parameter int addr_width_p    = 32,
    parameter int opq_width_p     = 8,
    parameter int load_id_width_p = 11
) (
    input  logic                                      clk_i,
    input  logic                                      reset_i,
    input  logic [num_chan_p-1:0]                     req_v_i,
    input  logic [num_chan_p-1:0]                     req_we_i,
    input  logic [num_chan_p-1:0][addr_width_p-1:0]   req_addr_i,
    input  logic [num_chan_p-1:0][data_width_p-1:0]   req_data_i,
    input  logic [num_chan_p-1:0][data_width_p/8-1:0] req_mask_i,
    input  logic [num_chan_p-1:0][opq_width_p-1:0]    req_opq_i,
    output logic [num_chan_p-1:0]                     req_ready_o,
    output logic                                      out_v_o,
    output logic                                      out_we_o,
    output logic [addr_width_p-1:0]                   out_addr_o,
    output logic [data_width_p-1:0]                   out_data_o,
    output logic [data_width_p/8-1:0]                 out_mask_o,
    output logic [load_id_width_p-1:0]                out_load_id_o,
    input  logic                                      out_ready_i,
    input  logic                                      returned_v_i,
    input  logic [load_id_width_p-1:0]                returned_load_id_i,
    input  logic [data_width_p-1:0]                   returned_data_i,
    output logic                                      returned_yumi_o,
    output logic [num_chan_p-1:0]                     resp_v_o,
    output logic [num_chan_p-1:0][data_width_p-1:0]   resp_data_o,
    output logic [num_chan_p-1:0][opq_width_p-1:0]    resp_opq_o,
    input  logic [num_chan_p-1:0]                     resp_ready_i,
    output logic                                      idle_o,
    output logic                                      err_o
);

    localparam int ChanW     = field_w(num_chan_p);
    localparam int SlotW     = field_w(max_out_p);
    localparam int SlotShift = $clog2(max_out_p);

    if (!load_id_fits(num_chan_p, max_out_p, load_id_width_p) || (load_id_width_p > 32)) begin : g_bad_load_id_width
        $error("load_id_width_p cannot hold the chan and slot fields");
    end

    logic [num_chan_p-1:0]                  eligible;
    logic [num_chan_p-1:0]                  has_free;
    logic [num_chan_p-1:0]                  alloc_v;
    logic [SlotW-1:0]                       alloc_slot [num_chan_p];
    logic [num_chan_p-1:0][max_out_p-1:0]   slot_busy;
    logic [num_chan_p-1:0]                  can_accept;
    logic [num_chan_p-1:0]                  tbl_resp_v;
    logic [num_chan_p-1:0]                  tbl_busy;
    logic [num_chan_p-1:0]                  ret_v;
    logic [ChanW-1:0]                       rr_r;
    logic [ChanW-1:0]                       grant;
    logic                                   grant_found;
    logic                                   handshake;
    load_id_s                               ret_dec;
    logic                                   ret_chan_ok;
    logic                                   ret_slot_ok;
    logic [ChanW-1:0]                       ret_chan;
    logic [SlotW-1:0]                       ret_slot;
    logic                                   ret_slot_alloc;
    logic                                   ret_good;
    logic                                   err_r;

    // Channel index visited at position off of a scan that starts at base.
    function automatic int rr_pick(input logic [ChanW-1:0] base, input int off);
        int k;
        k = int'(base) + off;
        if (k >= num_chan_p) begin
            k = k - num_chan_p;
        end
        return k;
    endfunction

    // Stores never need a slot; loads need one free slot in their channel.
    assign eligible  = req_v_i & (req_we_i | has_free) & {num_chan_p{~reset_i}};
    assign out_v_o   = |eligible;
    assign handshake = out_v_o & out_ready_i;
    assign alloc_v   = req_ready_o & ~req_we_i;

    // Round-robin pick: first eligible channel at or after the pointer.
    always_comb begin
        grant       = '0;
        grant_found = 1'b0;
        for (int i = 0; i < num_chan_p; i++) begin
            if (!grant_found && eligible[rr_pick(rr_r, i)]) begin
                grant_found = 1'b1;
                grant       = ChanW'(rr_pick(rr_r, i));
            end
        end
    end

    // Only the granted channel sees ready, and only when the endpoint takes it.
    always_comb begin
        req_ready_o = '0;
        if (handshake) begin
            req_ready_o[grant] = 1'b1;
        end
    end

    assign out_we_o   = req_we_i[grant];
    assign out_addr_o = req_addr_i[grant];
    assign out_data_o = req_data_i[grant];
    assign out_mask_o = req_mask_i[grant];

    // Loads carry {chan, slot}; stores carry zero.
    always_comb begin
        out_load_id_o = '0;
        if (out_v_o && !out_we_o) begin
            out_load_id_o = load_id_width_p'(encode_load_id(32'(grant), 32'(alloc_slot[grant]), SlotShift));
        end
    end

    // Pointer moves past the winner only when a request is actually handed off.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rr_r <= '0;
        end else if (handshake) begin
            rr_r <= (rr_pick(grant, 1) == 0) ? '0 : ChanW'(rr_pick(grant, 1));
        end
    end

    assign ret_dec        = decode_load_id(32'(returned_load_id_i), SlotShift);
    assign ret_chan_ok    = (ret_dec.chan < 32'(num_chan_p));
    assign ret_slot_ok    = (ret_dec.slot < 32'(max_out_p));
    assign ret_chan       = ChanW'(ret_dec.chan);
    assign ret_slot       = SlotW'(ret_dec.slot);
    assign ret_slot_alloc = ret_chan_ok & ret_slot_ok & slot_busy[ret_chan][ret_slot];

    // Bad channels are always swallowed; good channels wait for response room.
    assign returned_yumi_o = returned_v_i & ~reset_i & (~ret_chan_ok | can_accept[ret_chan]);
    assign ret_good        = returned_yumi_o & ret_slot_alloc;

    // Any consumed return that does not match a live slot is a sticky error.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            err_r <= 1'b0;
        end else if (returned_yumi_o && !ret_slot_alloc) begin
            err_r <= 1'b1;
        end
    end

    assign err_o    = err_r;
    assign idle_o   = ~(|tbl_busy);
    assign resp_v_o = tbl_resp_v & {num_chan_p{~reset_i}};

    for (genvar c = 0; c < num_chan_p; c++) begin : g_chan
        assign ret_v[c] = ret_good & (ret_chan == ChanW'(c));

        brg_xcel_tag_table #(
            .max_out_p    (max_out_p),
            .opq_width_p  (opq_width_p),
            .data_width_p (data_width_p)
        ) tag_table (
            .clk_i        (clk_i),
            .reset_i      (reset_i),
            .alloc_v_i    (alloc_v[c]),
            .alloc_opq_i  (req_opq_i[c]),
            .alloc_slot_o (alloc_slot[c]),
            .has_free_o   (has_free[c]),
            .slot_busy_o  (slot_busy[c]),
            .ret_v_i      (ret_v[c]),
            .ret_slot_i   (ret_slot),
            .ret_data_i   (returned_data_i),
            .can_accept_o (can_accept[c]),
            .resp_v_o     (tbl_resp_v[c]),
            .resp_data_o  (resp_data_o[c]),
            .resp_opq_o   (resp_opq_o[c]),
            .resp_ready_i (resp_ready_i[c]),
            .busy_o       (tbl_busy[c])
        );
    end

endmodule

// File: tb/tb_brg_xcel_mem_adapter.sv
// Directed self-checking bench for the accelerator memory-master adapter.
// Expected responses are queued when a return is handed in and checked when
// the adapter presents them on its response ports.
module tb_brg_xcel_mem_adapter;

    localparam int NumChan = 2;
    localparam int MaxOut  = 8;
    localparam int DataW   = 32;
    localparam int AddrW   = 32;
    localparam int OpqW    = 8;
    localparam int LidW    = 11;

    logic                                clk = 1'b0;
    logic                                reset;
    logic [NumChan-1:0]                  req_v;
    logic [NumChan-1:0]                  req_we;
    logic [NumChan-1:0][AddrW-1:0]       req_addr;
    logic [NumChan-1:0][DataW-1:0]       req_data;
    logic [NumChan-1:0][DataW/8-1:0]     req_mask;
    logic [NumChan-1:0][OpqW-1:0]        req_opq;
    logic [NumChan-1:0]                  req_ready;
    logic                                out_v;
    logic                                out_we;
    logic [AddrW-1:0]                    out_addr;
    logic [DataW-1:0]                    out_data;
    logic [DataW/8-1:0]                  out_mask;
    logic [LidW-1:0]                     out_load_id;
    logic                                out_ready;
    logic                                returned_v;
    logic [LidW-1:0]                     returned_load_id;
    logic [DataW-1:0]                    returned_data;
    logic                                returned_yumi;
    logic [NumChan-1:0]                  resp_v;
    logic [NumChan-1:0][DataW-1:0]       resp_data;
    logic [NumChan-1:0][OpqW-1:0]        resp_opq;
    logic [NumChan-1:0]                  resp_ready;
    logic                                idle;
    logic                                err;

    typedef struct {
        int              chan;
        logic [DataW-1:0] data;
        logic [OpqW-1:0]  opq;
    } exp_resp_t;

    exp_resp_t      exp_q [$];
    logic [OpqW-1:0] opq_model [NumChan][MaxOut];
    int             exp_rr;
    int             checks = 0;
    int             errors = 0;

    always #5 clk = ~clk;

    brg_xcel_mem_adapter #(
        .num_chan_p      (NumChan),
        .max_out_p       (MaxOut),
        .data_width_p    (DataW),
        .addr_width_p    (AddrW),
        .opq_width_p     (OpqW),
        .load_id_width_p (LidW)
    ) dut (
        .clk_i              (clk),
        .reset_i            (reset),
        .req_v_i            (req_v),
        .req_we_i           (req_we),
        .req_addr_i         (req_addr),
        .req_data_i         (req_data),
        .req_mask_i         (req_mask),
        .req_opq_i          (req_opq),
        .req_ready_o        (req_ready),
        .out_v_o            (out_v),
        .out_we_o           (out_we),
        .out_addr_o         (out_addr),
        .out_data_o         (out_data),
        .out_mask_o         (out_mask),
        .out_load_id_o      (out_load_id),
        .out_ready_i        (out_ready),
        .returned_v_i       (returned_v),
        .returned_load_id_i (returned_load_id),
        .returned_data_i    (returned_data),
        .returned_yumi_o    (returned_yumi),
        .resp_v_o           (resp_v),
        .resp_data_o        (resp_data),
        .resp_opq_o         (resp_opq),
        .resp_ready_i       (resp_ready),
        .idle_o             (idle),
        .err_o              (err)
    );

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(negedge clk);
        req_v      = '0;
        req_we     = '0;
        returned_v = 1'b0;
        out_ready  = 1'b1;
    endtask

    task automatic apply_stimulus(input int c, input logic we, input logic [AddrW-1:0] addr,
                                  input logic [DataW-1:0] data, input logic [OpqW-1:0] opq);
        req_v[c]    = 1'b1;
        req_we[c]   = we;
        req_addr[c] = addr;
        req_data[c] = data;
        req_mask[c] = 4'hF;
        req_opq[c]  = opq;
    endtask

    task automatic drive_return(input int c, input int slot, input logic [DataW-1:0] data);
        returned_v       = 1'b1;
        returned_load_id = LidW'(c * MaxOut + slot);
        returned_data    = data;
    endtask

    task automatic expect_load(input string tag, input int c, input int slot,
                               input logic [AddrW-1:0] addr, input logic [OpqW-1:0] opq);
        check_output({tag, "_out_v"}, 64'(out_v), 64'(1));
        check_output({tag, "_ready"}, 64'(req_ready), 64'(1 << c));
        check_output({tag, "_we"}, 64'(out_we), 64'(0));
        check_output({tag, "_addr"}, 64'(out_addr), 64'(addr));
        check_output({tag, "_id"}, 64'(out_load_id), 64'(c * MaxOut + slot));
        opq_model[c][slot] = opq;
    endtask

    task automatic accept_return(input string tag, input int c, input int slot, input logic [DataW-1:0] data);
        check_output({tag, "_yumi"}, 64'(returned_yumi), 64'(1));
        exp_q.push_back('{chan: c, data: data, opq: opq_model[c][slot]});
    endtask

    task automatic check_resp(input string tag, input logic [NumChan-1:0] exp_v);
        check_output({tag, "_resp_v"}, 64'(resp_v), 64'(exp_v));
        for (int c = 0; c < NumChan; c++) begin
            if (exp_v[c]) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $error("[TB] FAIL %s_sb observed=response expected=none", tag);
                end else begin
                    check_output({tag, "_data"}, 64'(resp_data[c]), 64'(exp_q[0].data));
                    check_output({tag, "_opq"}, 64'(resp_opq[c]), 64'(exp_q[0].opq));
                    if (resp_ready[c]) begin
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    endtask

    initial begin
        int g;
        reset            = 1'b1;
        req_v            = '0;
        req_we           = '0;
        req_addr         = '0;
        req_data         = '0;
        req_mask         = '0;
        req_opq          = '0;
        out_ready        = 1'b1;
        returned_v       = 1'b0;
        returned_load_id = '0;
        returned_data    = '0;
        resp_ready       = 2'b11;
        exp_rr           = 0;

        // Reset forces every handshake output low even with traffic present.
        next_cycle();
        apply_stimulus(0, 1'b1, 32'h10, 32'h1, 8'h1);
        apply_stimulus(1, 1'b1, 32'h20, 32'h2, 8'h2);
        drive_return(0, 0, 32'h0);
        #1;
        check_output("rst_out_v", 64'(out_v), 64'(0));
        check_output("rst_ready", 64'(req_ready), 64'(0));
        check_output("rst_yumi", 64'(returned_yumi), 64'(0));
        check_output("rst_resp_v", 64'(resp_v), 64'(0));
        next_cycle();
        next_cycle();
        reset = 1'b0;
        #1;
        check_output("rst_idle", 64'(idle), 64'(1));
        check_output("rst_err", 64'(err), 64'(0));
        check_resp("rst", 2'b00);
        check_output("rst_idle_out_v", 64'(out_v), 64'(0));

        // Single ch0 load followed by its return.
        next_cycle();
        apply_stimulus(0, 1'b0, 32'h100, 32'h0, 8'h5A);
        #1;
        expect_load("t1_load", 0, 0, 32'h100, 8'h5A);
        exp_rr = 1;
        next_cycle();
        drive_return(0, 0, 32'hDEADBEEF);
        #1;
        check_output("t1_busy", 64'(idle), 64'(0));
        accept_return("t1_ret", 0, 0, 32'hDEADBEEF);
        check_resp("t1_pre", 2'b00);
        next_cycle();
        #1;
        check_resp("t1_resp", 2'b01);
        next_cycle();
        #1;
        check_resp("t1_post", 2'b00);
        check_output("t1_idle", 64'(idle), 64'(1));

        // Both channels store continuously: grants alternate.
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            apply_stimulus(0, 1'b1, 32'h1000 + k, 32'hA0 + k, 8'h0);
            apply_stimulus(1, 1'b1, 32'h2000 + k, 32'hB0 + k, 8'h0);
            #1;
            g = exp_rr;
            check_output("t2_ready", 64'(req_ready), 64'(1 << g));
            check_output("t2_data", 64'(out_data), 64'((g == 1) ? (32'hB0 + k) : (32'hA0 + k)));
            check_output("t2_id", 64'(out_load_id), 64'(0));
            check_resp("t2", 2'b00);
            exp_rr = (g + 1) % NumChan;
        end
        next_cycle();
        out_ready = 1'b0;
        apply_stimulus(0, 1'b1, 32'h1100, 32'hC0, 8'h0);
        apply_stimulus(1, 1'b1, 32'h2100, 32'hD0, 8'h0);
        #1;
        check_output("t2_stall_v", 64'(out_v), 64'(1));
        check_output("t2_stall_ready", 64'(req_ready), 64'(0));
        next_cycle();
        apply_stimulus(0, 1'b1, 32'h1100, 32'hC0, 8'h0);
        apply_stimulus(1, 1'b1, 32'h2100, 32'hD0, 8'h0);
        #1;
        check_output("t2_resume", 64'(req_ready), 64'(1 << exp_rr));
        exp_rr = (exp_rr + 1) % NumChan;

        // ch1 fills all its slots; ch0 keeps issuing; one return reopens ch1.
        for (int s = 0; s < MaxOut; s++) begin
            next_cycle();
            apply_stimulus(1, 1'b0, 32'h200 + 4 * s, 32'h0, 8'h10 + 8'(s));
            #1;
            expect_load("t3_fill", 1, s, 32'h200 + 4 * s, 8'h10 + 8'(s));
            exp_rr = 0;
        end
        next_cycle();
        apply_stimulus(1, 1'b0, 32'h300, 32'h0, 8'h77);
        apply_stimulus(0, 1'b0, 32'h400, 32'h0, 8'h33);
        #1;
        expect_load("t3_ch0", 0, 0, 32'h400, 8'h33);
        exp_rr = 1;
        next_cycle();
        apply_stimulus(1, 1'b0, 32'h300, 32'h0, 8'h77);
        drive_return(1, 5, 32'h55550005);
        #1;
        check_output("t3_full_ready", 64'(req_ready), 64'(0));
        check_output("t3_full_v", 64'(out_v), 64'(0));
        accept_return("t3_ret", 1, 5, 32'h55550005);
        next_cycle();
        apply_stimulus(1, 1'b0, 32'h300, 32'h0, 8'h77);
        #1;
        expect_load("t3_reissue", 1, 5, 32'h300, 8'h77);
        check_resp("t3_resp", 2'b10);
        exp_rr = 0;
        next_cycle();
        #1;
        check_resp("t3_post", 2'b00);

        // ch0 response held back; out-of-order returns keep their opaques.
        resp_ready = 2'b10;
        for (int s = 1; s <= 3; s++) begin
            next_cycle();
            apply_stimulus(0, 1'b0, 32'h500 + 4 * s, 32'h0, 8'hA0 + 8'(s));
            #1;
            expect_load("t4_load", 0, s, 32'h500 + 4 * s, 8'hA0 + 8'(s));
        end
        next_cycle();
        drive_return(0, 3, 32'h33330003);
        #1;
        accept_return("t4_ret3", 0, 3, 32'h33330003);
        for (int k = 0; k < 2; k++) begin
            next_cycle();
            drive_return(0, 1, 32'h11110001);
            #1;
            check_output("t4_blocked_yumi", 64'(returned_yumi), 64'(0));
            check_resp("t4_hold", 2'b01);
        end
        next_cycle();
        resp_ready = 2'b11;
        drive_return(0, 1, 32'h11110001);
        #1;
        check_resp("t4_drain", 2'b01);
        accept_return("t4_ret1", 0, 1, 32'h11110001);
        next_cycle();
        #1;
        check_resp("t4_second", 2'b01);
        next_cycle();
        #1;
        check_resp("t4_post", 2'b00);

        // Protocol errors: unallocated slot, then a channel that does not exist.
        next_cycle();
        drive_return(0, 5, 32'hBAD0BAD0);
        #1;
        check_output("t5_err_before", 64'(err), 64'(0));
        check_output("t5_bad_slot_yumi", 64'(returned_yumi), 64'(1));
        next_cycle();
        #1;
        check_output("t5_err_set", 64'(err), 64'(1));
        check_resp("t5_dropped", 2'b00);
        next_cycle();
        returned_v       = 1'b1;
        returned_load_id = 11'h018;
        returned_data    = 32'hBAD1BAD1;
        #1;
        check_output("t5_bad_chan_yumi", 64'(returned_yumi), 64'(1));
        next_cycle();
        next_cycle();
        #1;
        check_output("t5_err_sticky", 64'(err), 64'(1));
        check_resp("t5_post", 2'b00);

        // Reset with loads outstanding discards them and rewinds arbitration.
        check_output("t6_busy", 64'(idle), 64'(0));
        next_cycle();
        reset = 1'b1;
        apply_stimulus(0, 1'b1, 32'h600, 32'h1, 8'h0);
        apply_stimulus(1, 1'b1, 32'h700, 32'h2, 8'h0);
        drive_return(1, 3, 32'h0);
        #1;
        check_output("t6_rst_out_v", 64'(out_v), 64'(0));
        check_output("t6_rst_yumi", 64'(returned_yumi), 64'(0));
        next_cycle();
        reset  = 1'b0;
        exp_rr = 0;
        #1;
        check_output("t6_idle", 64'(idle), 64'(1));
        check_output("t6_err_clr", 64'(err), 64'(0));
        check_resp("t6", 2'b00);
        next_cycle();
        apply_stimulus(0, 1'b1, 32'h600, 32'h1, 8'h0);
        apply_stimulus(1, 1'b1, 32'h700, 32'h2, 8'h0);
        #1;
        check_output("t6_rr_zero", 64'(req_ready), 64'(1 << exp_rr));
        next_cycle();
        drive_return(1, 3, 32'h0);
        #1;
        check_output("t6_stale_yumi", 64'(returned_yumi), 64'(1));
        next_cycle();
        #1;
        check_output("t6_stale_err", 64'(err), 64'(1));
        check_resp("t6_stale", 2'b00);
        check_output("sb_drained", 64'(exp_q.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/brg_xcel_mem_adapter.md
# brg_xcel_mem_adapter

Parametrised memory-master adapter between N accelerator request channels and one manycore endpoint master port. Arbitrates the channels round-robin and tags each load with a channel/slot load ID. Keeps a per-channel table of caller opaque values and routes returned loads back to the issuing channel through a registered, back-pressurable response stage. It generalises the single-channel, always-ready, opaque-equals-load-ID xcel master path. It sits between the accelerator core(s) and `bsg_manycore_pkt_encode`/`bsg_manycore_endpoint_standard` in an xcel tile.

## Interface
- `num_chan_p`, 2: number of accelerator request channels (≥1).
- `max_out_p`, 8: outstanding loads per channel (power of 2).
- `data_width_p`, 32: data width.
- `addr_width_p`, 32: address width.
- `opq_width_p`, 8: caller opaque field width.
- `load_id_width_p`, 11: endpoint load-ID width; elaboration error if < `clog2(num_chan_p)+clog2(max_out_p)`.

Ports:
- `clk_i`  in  1  clock.
- `reset_i`  in  1  synchronous, active-high reset.
- `req_v_i`  in  `num_chan_p`  per-channel request valid.
- `req_we_i`  in  `num_chan_p`  1 = store, 0 = load.
- `req_addr_i`  in  `num_chan_p`×`addr_width_p`  address.
- `req_data_i`  in  `num_chan_p`×`data_width_p`  store data.
- `req_mask_i`  in  `num_chan_p`×`data_width_p/8`  byte mask.
- `req_opq_i`  in  `num_chan_p`×`opq_width_p`  opaque value, returned with the load data.
- `req_ready_o`  out  `num_chan_p`  request accepted when valid and ready are both high.
- `out_v_o`  out  1  endpoint request valid.
- `out_we_o`, `out_addr_o`, `out_data_o`, `out_mask_o`  out  –  muxed request fields.
- `out_load_id_o`  out  `load_id_width_p`  load ID = {zero pad, chan, slot}.
- `out_ready_i`  in  1  endpoint ready.
- `returned_v_i`  in  1  endpoint load return valid.
- `returned_load_id_i`  in  `load_id_width_p`  returned load ID.
- `returned_data_i`  in  `data_width_p`  returned data.
- `returned_yumi_o`  out  1  return consumed.
- `resp_v_o`  out  `num_chan_p`  per-channel response valid.
- `resp_data_o`  out  `num_chan_p`×`data_width_p`  response data.
- `resp_opq_o`  out  `num_chan_p`×`opq_width_p`  opaque value of the matching request.
- `resp_ready_i`  in  `num_chan_p`  response accepted.
- `idle_o`  out  1  no loads outstanding and no responses held.
- `err_o`  out  1  sticky protocol error.

## Operation
- **Eligibility.** A channel is eligible when `req_v_i` is high and either `req_we_i=1` (stores take no slot) or it has a free slot.
- **Arbitration.** Round-robin over eligible channels, starting at pointer `rr_r`. `out_v_o` = any channel eligible; it never depends on `out_ready_i`. The pointer advances to grant+1 (mod `num_chan_p`) only on a handshake (`out_v_o & out_ready_i`).
- **Ready.** `req_ready_o[c]` = grant==c & `out_ready_i`.
- **Load allocation.** An accepted load takes the lowest free slot of its channel and writes `req_opq_i` into it. `out_load_id_o` carries {c, slot}. For stores, `out_load_id_o`=0.
- **Return.** `returned_load_id_i` is decoded to {chan, slot}. `returned_yumi_o` = `returned_v_i` & (response register of chan empty, or being drained this cycle). On yumi:
  - register data and the stored opaque value into chan's response register;
  - free the slot.
- **Errors.** A return whose chan ≥ `num_chan_p`, or whose slot is not allocated, is yumied and dropped, and sets `err_o`. Only reset clears `err_o`.
- **Response handoff.** The response register is cleared when `resp_v_o[c]` and `resp_ready_i[c]` are both high.

## Timing
- Request path is combinational: 0-cycle latency, request to `out_*`.
- Response path: yumi at cycle t → `resp_v_o` high at t+1. At most one return is accepted per cycle.
- **Slot timing.**
  - A slot freed at t is allocatable from t+1; allocation uses the registered free vector.
  - Allocating the last free slot drops that channel's eligibility for loads from t+1.
- **Full response register.** Drain and refill in the same cycle are allowed (full throughput).
- **Reset.**
  - State: all slots free; response registers empty; `rr_r`=0; `err_o`=0; `idle_o`=1.
  - While `reset_i` is high, `out_v_o`, `req_ready_o`, `returned_yumi_o` and `resp_v_o` are all forced to 0.
  - Reset mid-operation discards outstanding state. Later returns then flag `err_o`; the system must quiesce before reset.
- `idle_o` is registered-state only: no slot allocated and no `resp_v_o` high.

## Structure
- Package `brg_xcel_pkg`: chan/slot field widths, the load-ID struct, and the elaboration width check.
- Sub-module `brg_xcel_tag_table`, instantiated once per channel. It holds:
  - the free vector;
  - the opaque RAM (`max_out_p`×`opq_width_p`);
  - the lowest-free priority encoder;
  - the response register.
- Round-robin arbiter: reuse `bsg_arb_round_robin`.

## Test plan
- **Single-channel load.** `num_chan_p`=2; ch0 load addr 0x100, opq 0x5A → `out_load_id_o`=0x000. Return id 0x000, data 0xDEADBEEF → next cycle `resp_v_o[0]`, data 0xDEADBEEF, opq 0x5A.
- **Contention.** Both channels issue stores continuously with `out_ready_i`=1 → grants alternate 0,1,0,1; no `resp_v_o`.
- **Slot exhaustion.** ch1 issues 8 loads without returns → 9th load sees `req_ready_o[1]`=0 while ch0 still issues. One return frees a slot; the load is accepted the cycle after.
- **Response backpressure.** Hold `resp_ready_i[0]`=0 with two ch0 returns pending → `returned_yumi_o` is low for the second return until `resp_ready_i[0]` rises. Out-of-order returns (slot 3 before slot 1) deliver correct opq values.
- **Errors.** Return id for unallocated slot, or chan=3 → yumied, `err_o`=1 and stays 1 until reset.
- **Reset mid-flight.** Assert `reset_i` with 4 loads outstanding → next cycle `idle_o`=1, `resp_v_o`=0, `rr_r`=0.
